// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - full-duplex UART with run-time baud divisor, optional parity and TX/RX FIFOs
// First-word fall-through FIFO with registered full/empty; the top-level UART is uart_fifo.

module uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             full_q, empty_q;

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, i_push};
        rd_d = rd_q + {{AW{1'b0}}, i_pop};
    end

    // Extra pointer MSB separates full from empty once the indices wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
            empty_q <= (wr_d == rd_d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_q[AW-1:0]] <= i_data;
    end

    assign o_data  = mem_q[rd_q[AW-1:0]];
    assign o_full  = full_q;
    assign o_empty = empty_q;
endmodule

module uart_fifo #(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 1,
    parameter int PARITY     = 0,
    parameter int DEPTH      = 16,
    parameter int WIDTH_DIV  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WIDTH_DIV-1:0]  i_div,
    input  logic                  i_rx,
    output logic                  o_tx,
    input  logic                  i_we,
    input  logic [WIDTH_DATA-1:0] i_data,
    output logic                  o_full,
    output logic                  o_mty,
    input  logic                  i_re,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_rdy,
    output logic                  o_perr,
    output logic                  o_ferr,
    output logic                  o_ovf,
    input  logic                  i_clr_ovf
);
    localparam logic       PAR_ODD   = (PARITY == 1);
    localparam logic [3:0] LAST_BIT  = 4'(WIDTH_DATA - 1);
    localparam logic       LAST_STOP = (NB_STOP == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [WIDTH_DIV-1:0] div_eff;
    assign div_eff = (i_div < WIDTH_DIV'(4)) ? WIDTH_DIV'(4) : i_div;

    state_t                tx_state_q;
    logic [WIDTH_DIV-1:0]  tx_div_q, tx_cnt_q;
    logic [WIDTH_DATA-1:0] tx_sh_q, tx_head;
    logic [3:0]            tx_bit_q;
    logic                  tx_stop_q, tx_par_q, tx_q;
    logic                  tx_push, tx_pop, tx_full, tx_empty, tx_last;

    assign tx_push = i_we && !tx_full;
    assign tx_last = (tx_state_q == S_STOP) && (tx_cnt_q == '0) && (tx_stop_q == LAST_STOP);
    assign tx_pop  = !tx_empty && ((tx_state_q == S_IDLE) || tx_last);

    uart_fifo_buf #(.WIDTH(WIDTH_DATA), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(tx_push), .i_data(i_data),
        .i_pop(tx_pop), .o_data(tx_head), .o_full(tx_full), .o_empty(tx_empty)
    );

    // A pop starts a frame from IDLE or straight out of the last stop bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state_q <= S_IDLE;
            tx_q       <= 1'b1;
            tx_div_q   <= '0;
            tx_cnt_q   <= '0;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_par_q   <= 1'b0;
        end else if (tx_pop) begin
            tx_state_q <= S_START;
            tx_q       <= 1'b0;
            tx_div_q   <= div_eff;
            tx_cnt_q   <= div_eff - 1'b1;
            tx_sh_q    <= tx_head;
            tx_par_q   <= (^tx_head) ^ PAR_ODD;
        end else if (tx_state_q != S_IDLE && tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
        end else begin
            tx_cnt_q <= tx_div_q - 1'b1;
            case (tx_state_q)
                S_START: begin
                    tx_state_q <= S_DATA;
                    tx_q       <= tx_sh_q[0];
                    tx_sh_q    <= tx_sh_q >> 1;
                    tx_bit_q   <= '0;
                end
                S_DATA: begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_stop_q <= 1'b0;
                        if (PARITY != 0) begin
                            tx_state_q <= S_PAR;
                            tx_q       <= tx_par_q;
                        end else begin
                            tx_state_q <= S_STOP;
                            tx_q       <= 1'b1;
                        end
                    end else begin
                        tx_q     <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 1'b1;
                    end
                end
                S_PAR: begin
                    tx_state_q <= S_STOP;
                    tx_q       <= 1'b1;
                    tx_stop_q  <= 1'b0;
                end
                S_STOP: begin
                    if (tx_stop_q == LAST_STOP) tx_state_q <= S_IDLE;
                    else                        tx_stop_q  <= 1'b1;
                end
                default: begin
                    tx_state_q <= S_IDLE;
                    tx_q       <= 1'b1;
                end
            endcase
        end
    end

    state_t                  rx_state_q;
    logic                    rx_s1_q, rx_s2_q, rx_prev_q;
    logic [WIDTH_DIV-1:0]    rx_div_q, rx_cnt_q;
    logic [WIDTH_DATA-1:0]   rx_sh_q;
    logic [3:0]              rx_bit_q;
    logic                    rx_stop_q, rx_perr_q, rx_ferr_q, rx_ovf_q;
    logic                    rx_push, rx_pop, rx_wr, rx_full, rx_empty;
    logic [WIDTH_DATA+1:0]   rx_word, rx_head;

    assign rx_push = (rx_state_q == S_STOP) && (rx_cnt_q == '0) && (rx_stop_q == LAST_STOP);
    assign rx_word = {rx_sh_q, rx_perr_q, rx_ferr_q | !rx_s2_q};
    assign rx_pop  = i_re && !rx_empty;
    assign rx_wr   = rx_push && (!rx_full || rx_pop);

    uart_fifo_buf #(.WIDTH(WIDTH_DATA + 2), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(rx_wr), .i_data(rx_word),
        .i_pop(rx_pop), .o_data(rx_head), .o_full(rx_full), .o_empty(rx_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_div_q   <= '0;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_stop_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            rx_s1_q   <= i_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (rx_push && rx_full && !rx_pop) rx_ovf_q <= 1'b1;
            else if (i_clr_ovf)                rx_ovf_q <= 1'b0;

            if (rx_state_q == S_IDLE) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_q <= S_START;
                    rx_div_q   <= div_eff;
                    rx_cnt_q   <= (div_eff >> 1) - 1'b1;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= rx_div_q - 1'b1;
                case (rx_state_q)
                    S_START: begin
                        if (rx_s2_q) begin
                            rx_state_q <= S_IDLE;
                        end else begin
                            rx_state_q <= S_DATA;
                            rx_bit_q   <= '0;
                            rx_perr_q  <= 1'b0;
                            rx_ferr_q  <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        rx_sh_q <= {rx_s2_q, rx_sh_q[WIDTH_DATA-1:1]};
                        if (rx_bit_q == LAST_BIT) begin
                            rx_stop_q  <= 1'b0;
                            rx_state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end
                    S_PAR: begin
                        rx_perr_q  <= rx_s2_q ^ (^rx_sh_q) ^ PAR_ODD;
                        rx_state_q <= S_STOP;
                        rx_stop_q  <= 1'b0;
                    end
                    S_STOP: begin
                        if (!rx_s2_q) rx_ferr_q <= 1'b1;
                        if (rx_stop_q == LAST_STOP) rx_state_q <= S_IDLE;
                        else                        rx_stop_q  <= 1'b1;
                    end
                    default: rx_state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_tx   = tx_q;
    assign o_full = tx_full;
    assign o_mty  = tx_empty && (tx_state_q == S_IDLE);
    assign o_rdy  = !rx_empty;
    assign o_data = o_rdy ? rx_head[WIDTH_DATA+1:2] : '0;
    assign o_perr = o_rdy & rx_head[1];
    assign o_ferr = o_rdy & rx_head[0];
    assign o_ovf  = rx_ovf_q;
endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - scoreboard bench for uart_fifo with loopback and injected RX frames

module tb_uart_fifo;
    localparam int WD = 8, NS = 2, PAR = 2, DEPTH = 4, WDIV = 16;
    localparam int FLEN = 1 + WD + ((PAR != 0) ? 1 : 0) + NS;

    logic            clk = 1'b0;
    logic            i_rst, i_rx, o_tx, i_we, o_full, o_mty, i_re, o_rdy, o_perr, o_ferr, o_ovf, i_clr_ovf;
    logic [WDIV-1:0] i_div;
    logic [WD-1:0]   i_data, o_data;
    logic            loop_en, rx_drv, mon_en;
    logic [WD+1:0]   exp_q[$];
    int              errs = 0, checks = 0;

    always #5 clk = ~clk;
    assign i_rx = loop_en ? o_tx : rx_drv;

    uart_fifo #(.WIDTH_DATA(WD), .NB_STOP(NS), .PARITY(PAR), .DEPTH(DEPTH), .WIDTH_DIV(WDIV)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_div(i_div), .i_rx(i_rx), .o_tx(o_tx),
        .i_we(i_we), .i_data(i_data), .o_full(o_full), .o_mty(o_mty),
        .i_re(i_re), .o_data(o_data), .o_rdy(o_rdy), .o_perr(o_perr), .o_ferr(o_ferr),
        .o_ovf(o_ovf), .i_clr_ovf(i_clr_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line-level frame: bit k is what the wire carries during bit time k.
    function automatic logic [15:0] frame_bits(input logic [WD-1:0] d, input logic bad_par, input logic bad_stop);
        logic [15:0] f;
        int ones, pos;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < WD; i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
        pos = 1 + WD;
        if (PAR != 0) begin
            f[pos] = ((PAR == 2) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ bad_par;
            pos++;
        end
        if (bad_stop) f[pos] = 1'b0;
        return f;
    endfunction

    task automatic send_frame(input logic [WD-1:0] d, input logic bp, input logic bs, input int div);
        logic [15:0] f;
        f = frame_bits(d, bp, bs);
        for (int k = 0; k < FLEN; k++) begin
            rx_drv = f[k];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic write_word(input logic [WD-1:0] d, input logic expect_rx);
        i_we   = 1'b1;
        i_data = d;
        if (expect_rx) exp_q.push_back({d, 2'b00});
        @(negedge clk);
        i_we = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !o_mty || o_rdy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || !o_mty || o_rdy) begin
            errs++;
            $display("FAIL %s: timeout with %0d words outstanding, mty=%0b", name, exp_q.size(), o_mty);
        end
    endtask

    initial begin
        logic [11:0]   spec_bits;
        logic [WD-1:0] w;
        logic          bp, bs;
        int            n, div;

        i_rst = 1'b1; i_div = 16'd8; i_we = 1'b0; i_data = '0; i_clr_ovf = 1'b0;
        i_re = 1'b0; loop_en = 1'b1; rx_drv = 1'b1; mon_en = 1'b1;

        fork
            forever begin
                logic [WD+1:0] e;
                @(negedge clk);
                i_re = 1'b0;
                if (mon_en && o_rdy && !i_rst) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL rx_unexpected: got %0h with nothing expected", {o_data, o_perr, o_ferr});
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_word", {o_data, o_perr, o_ferr}, e);
                    end
                    i_re = 1'b1;
                end
            end
        join_none

        repeat (2) @(negedge clk);
        check("rst_tx", o_tx, 1);     check("rst_full", o_full, 0);
        check("rst_mty", o_mty, 1);   check("rst_rdy", o_rdy, 0);
        check("rst_data", o_data, 0); check("rst_perr", o_perr, 0);
        check("rst_ferr", o_ferr, 0); check("rst_ovf", o_ovf, 0);
        i_rst = 1'b0;
        @(negedge clk);

        // Loopback of 0xA5 with even parity and two stops.
        spec_bits = 12'b1101_0100_1010;
        write_word(8'hA5, 1'b1);
        check("mty_fall", o_mty, 0);
        check("tx_idle_n1", o_tx, 1);
        @(negedge clk);
        check("tx_start", o_tx, 0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            check("tx_bit", o_tx, spec_bits[k]);
            if (k < 11) repeat (8) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("mty_last_stop", o_mty, 0);
        @(negedge clk);
        check("mty_rise", o_mty, 1);
        wait_drain("drain_a5", 400);

        // Random loopback bursts, including divisors clamped to 4.
        for (int r = 0; r < 4; r++) begin
            i_div = 16'($urandom_range(2, 12));
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++) write_word(8'($urandom), 1'b1);
            wait_drain("drain_rand", 3000);
        end

        // TX FIFO full while the transmitter is busy with a long frame.
        i_div = 16'd8;
        write_word(8'($urandom), 1'b1);
        repeat (2) @(negedge clk);
        for (int k = 0; k <= DEPTH; k++) begin
            check("tx_full", o_full, (k >= DEPTH));
            write_word(8'($urandom), (k < DEPTH));
        end
        check("tx_full_end", o_full, 1);
        wait_drain("drain_full", 3000);

        // Short glitch on the RX line is rejected.
        loop_en = 1'b0;
        i_div = 16'd16;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_rdy", o_rdy, 0);

        // Parity and framing errors, then random error mixes.
        div = 8;
        i_div = 16'(div);
        exp_q.push_back({8'h3C, 2'b10});
        send_frame(8'h3C, 1'b1, 1'b0, div);
        exp_q.push_back({8'h3C, 2'b01});
        send_frame(8'h3C, 1'b0, 1'b1, div);
        for (int r = 0; r < 6; r++) begin
            w  = 8'($urandom);
            bp = 1'($urandom);
            bs = 1'($urandom);
            exp_q.push_back({w, bp, bs});
            send_frame(w, bp, bs, div);
        end
        wait_drain("drain_err", 400);

        // Overrun: DEPTH frames kept, one more dropped.
        mon_en = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            w = 8'($urandom);
            exp_q.push_back({w, 2'b00});
            send_frame(w, 1'b0, 1'b0, div);
        end
        repeat (2) @(negedge clk);
        check("ovf_before", o_ovf, 0);
        check("rdy_full", o_rdy, 1);
        send_frame(8'($urandom), 1'b0, 1'b0, div);
        repeat (2) @(negedge clk);
        check("ovf_set", o_ovf, 1);
        mon_en = 1'b1;
        wait_drain("drain_ovf", 400);
        check("ovf_sticky", o_ovf, 1);
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        check("ovf_clr", o_ovf, 0);

        // Reset in the middle of a TX data bit, then a clean frame.
        loop_en = 1'b1;
        write_word(8'h5A, 1'b0);
        n = 0;
        while (o_tx && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx_fall_seen", o_tx, 0);
        repeat (3 * div + 4) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", o_tx, 1);
        check("rst_mid_mty", o_mty, 1);
        check("rst_mid_rdy", o_rdy, 0);
        i_rst = 1'b0;
        @(negedge clk);
        write_word(8'hC3, 1'b1);
        wait_drain("drain_after_rst", 400);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised full-duplex UART core with a run-time baud divisor, optional parity, and power-of-two TX/RX FIFOs. It replaces the fixed-divider, single-word UART and sits between the chip pins (`i_rx`/`o_tx`) and an internal bus master that pushes TX words and pops RX words through valid/ready-style strobes. Each RX word carries its own parity and framing error status; overrun is reported as a sticky flag.

## Interface
- `WIDTH_DATA`, 8: data bits per frame. Legal range 5..9.
- `NB_STOP`, 1: stop bits, 1 or 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `DEPTH`, 16: entries per FIFO. Power of two, at least 2.
- `WIDTH_DIV`, 16: width of the baud divisor.

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_div` in `WIDTH_DIV`: clock cycles per bit. Minimum 4; values below 4 are used as 4.
- `i_rx` in 1: serial input, asynchronous.
- `o_tx` out 1: serial output, registered.
- `i_we` in 1: push `i_data` into the TX FIFO.
- `i_data` in `WIDTH_DATA`: TX word.
- `o_full` out 1: TX FIFO full.
- `o_mty` out 1: TX FIFO empty and transmitter idle.
- `i_re` in 1: pop the RX FIFO head.
- `o_data` out `WIDTH_DATA`: RX FIFO head (first-word fall-through).
- `o_rdy` out 1: RX FIFO not empty.
- `o_perr` out 1: head word has a parity error.
- `o_ferr` out 1: head word has a framing error.
- `o_ovf` out 1: sticky overrun flag.
- `i_clr_ovf` in 1: clear `o_ovf`.

## Operation
- Reset values: `o_tx`=1, `o_full`=0, `o_mty`=1, `o_rdy`=0, `o_data`=0, `o_perr`=0, `o_ferr`=0, `o_ovf`=0. Reset also empties both FIFOs and sends both FSMs to IDLE.
- Reset in mid-frame aborts the frame; `o_tx` returns to 1 on the next edge.

TX FIFO:
- `i_we` while `o_full`=1 is ignored, even if the transmitter pops in the same cycle.
- Pointers are log2(DEPTH)+1 bits so full and empty are distinguished on wrap.

TX FSM: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE.
- IDLE pops the FIFO when it is non-empty and latches `i_div` for the whole frame.
- Each bit lasts exactly the latched divisor number of cycles.
- Data is sent LSB first.
- The parity bit is the XOR of the data bits for even parity, its inverse for odd.
- STOP drives 1 for `NB_STOP` bit times.
- Back-to-back frames have no idle gap: STOP goes directly to START when the FIFO is non-empty.

RX synchroniser and FSM: `i_rx` passes through two flops first. States are IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE leaves on a 1→0 transition of the synchronised input and latches `i_div` (value d).
- START samples at d/2 (floor) cycles. If the line is 1 there, the start is rejected as a glitch and the FSM returns to IDLE.
- Every later bit is sampled d cycles after the previous sample.
- The parity check uses the same rule as TX; a mismatch sets the word's perr.
- Every stop bit is sampled; any 0 sets the word's ferr.
- After the last stop-bit sample the FSM returns to IDLE and re-arms for a new edge immediately.
- The word plus {perr, ferr} is pushed into the RX FIFO (WIDTH_DATA+2 bits wide).
- A push while the RX FIFO is full drops the word and sets `o_ovf`. `o_ovf` stays set until `i_clr_ovf`; if both happen in one cycle, the set wins.
- `i_re` while `o_rdy`=0 is ignored. When `i_re` and a push coincide on a full FIFO, the pop happens first and the push succeeds.

## Timing
- TX start: `i_we` in cycle N into an empty FIFO with TX idle makes `o_mty` fall in N+1 and `o_tx` fall in N+2.
- TX frame length: (1 + WIDTH_DATA + (PARITY≠0) + NB_STOP) × d cycles.
- `o_mty` rises in the cycle after the last stop bit ends, provided the FIFO is empty.
- RX latency: `o_rdy`, `o_data` and the error flags update 1 cycle after the final stop-bit sample.
- `i_re` in cycle N: the next head, or `o_rdy`=0, is visible in N+1.
- `o_full` and `o_rdy` are registered from the pointers and reflect push/pop in the following cycle.

## Test plan
- Loopback with `i_rx`=`o_tx`, `i_div`=8, `WIDTH_DATA`=8, `PARITY`=2, `NB_STOP`=2, write 0xA5 → `o_tx` shows bits 0,1,0,1,0,0,1,0,1,0,1,1 at 8 cycles each; `o_rdy` rises and `o_data`=0xA5 with `o_perr`=0 and `o_ferr`=0.
- Write DEPTH+1 words with TX stalled from the start → `o_full`=1 after DEPTH accepted writes; the extra word is never transmitted; all DEPTH words are received in order.
- Drive a 3-cycle low pulse on `i_rx` with `i_div`=16 → no word is pushed; `o_rdy` stays 0.
- Inject a frame of 0x3C with an inverted parity bit, then a frame of 0x3C with the first stop bit 0 → head entries are {0x3C, perr=1, ferr=0} then {0x3C, perr=0, ferr=1}.
- Receive DEPTH+1 frames without `i_re` → `o_ovf`=1, the first DEPTH words are intact, the last word is dropped; `i_clr_ovf` clears the flag.
- Assert `i_rst` in the middle of the DATA state of a TX frame → `o_tx`=1 and `o_mty`=1 in the next cycle; a subsequent write transmits cleanly.
